// File: rtl/fight_pkg.sv
// Shared definitions for the fighting-game blocks: action codes, winner encoding,
// sequencer states and the small location/health constants.
package fight_pkg;

    localparam int unsigned ACTION_W = 6;

    localparam logic [ACTION_W-1:0] ACT_NONE       = 6'b000000;
    localparam logic [ACTION_W-1:0] ACT_MOVE_RIGHT = 6'b100000;
    localparam logic [ACTION_W-1:0] ACT_MOVE_LEFT  = 6'b010000;
    localparam logic [ACTION_W-1:0] ACT_WAIT       = 6'b001000;
    localparam logic [ACTION_W-1:0] ACT_JUMP       = 6'b000100;
    localparam logic [ACTION_W-1:0] ACT_KICK       = 6'b000010;
    localparam logic [ACTION_W-1:0] ACT_PUNCH      = 6'b000001;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;
    localparam logic [1:0] THREE = 2'd3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNTDOWN  = 3'd1,
        FIGHT      = 3'd2,
        ROUND_END  = 3'd3,
        MATCH_OVER = 3'd4
    } fight_state_e;

    // Anything other than one of the six legal codes becomes a no-op.
    function automatic logic [ACTION_W-1:0] sanitize_action(input logic [ACTION_W-1:0] action);
        logic [ACTION_W-1:0] result;
        case (action)
            ACT_MOVE_RIGHT, ACT_MOVE_LEFT, ACT_WAIT,
            ACT_JUMP, ACT_KICK, ACT_PUNCH: result = action;
            default:                       result = ACT_NONE;
        endcase
        return result;
    endfunction

    function automatic logic is_strike(input logic [ACTION_W-1:0] action);
        return (action == ACT_PUNCH) || (action == ACT_KICK);
    endfunction

    // Larger value wins; a tie is a draw.
    function automatic logic [1:0] pick_winner(input logic [1:0] left_val, input logic [1:0] right_val);
        logic [1:0] result;
        if (left_val > right_val) begin
            result = WIN_LEFT;
        end else if (right_val > left_val) begin
            result = WIN_RIGHT;
        end else begin
            result = WIN_DRAW;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into action ticks; tick marks count 0, eval marks count 2.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic eval
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || (count == CNT_W'(TICK_DIV - 1))) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == '0);
    assign eval = (count == CNT_W'(2));

endmodule

// File: rtl/fight_round_controller.sv
// Match sequencer: paces action ticks, forwards sanitized player actions, judges
// rounds by KO or timeout and keeps the best-of match score.
module fight_round_controller
    import fight_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 4,
    parameter int unsigned COUNTDOWN_TICKS = 3,
    parameter int unsigned ROUND_TICKS     = 30,
    parameter int unsigned ROUND_END_TICKS = 2,
    parameter int unsigned WINS_TO_MATCH   = 2,
    parameter int unsigned MAX_ROUNDS      = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [5:0]                         left_player_input,
    input  logic [5:0]                         right_player_input,
    input  logic [1:0]                         left_player_health,
    input  logic [1:0]                         right_player_health,
    output logic [5:0]                         left_cmd,
    output logic [5:0]                         right_cmd,
    output logic                               players_rst_n,
    output logic [$clog2(ROUND_TICKS+1)-1:0]   round_timer,
    output logic [1:0]                         left_wins,
    output logic [1:0]                         right_wins,
    output logic [1:0]                         round_winner,
    output logic                               match_over,
    output logic [1:0]                         match_winner,
    output logic [2:0]                         state
);

    localparam int unsigned TIMER_W   = $clog2(ROUND_TICKS + 1);
    localparam int unsigned ROUND_W   = $clog2(MAX_ROUNDS + 1);
    localparam int unsigned PHASE_MAX = (COUNTDOWN_TICKS > ROUND_END_TICKS) ? COUNTDOWN_TICKS
                                                                             : ROUND_END_TICKS;
    localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

    fight_state_e        state_q;
    logic                tick;
    logic                eval;
    logic [PHASE_W-1:0]  phase_cnt;
    logic [ROUND_W-1:0]  round_count;
    logic [1:0]          prev_left_health;
    logic [1:0]          prev_right_health;
    logic [5:0]          last_left_cmd;
    logic [5:0]          last_right_cmd;

    logic [5:0]          left_act_c;
    logic [5:0]          right_act_c;
    logic                left_ko_c;
    logic                right_ko_c;
    logic [1:0]          result_c;
    logic [PHASE_W-1:0]  phase_last_c;
    logic                phase_done_c;
    logic                match_done_c;
    logic                start_ok_c;
    logic                enter_countdown_c;
    logic                clear_c;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_c),
        .tick  (tick),
        .eval  (eval)
    );

    // Round judgement and phase bookkeeping decisions.
    always_comb begin
        left_act_c  = sanitize_action(left_player_input);
        right_act_c = sanitize_action(right_player_input);

        // A health rise right after being struck means the 2-bit counter wrapped.
        left_ko_c  = (left_player_health == '0)
                  || ((left_player_health > prev_left_health) && is_strike(last_right_cmd));
        right_ko_c = (right_player_health == '0)
                  || ((right_player_health > prev_right_health) && is_strike(last_left_cmd));

        result_c = WIN_NONE;
        if (left_ko_c && right_ko_c) begin
            result_c = WIN_DRAW;
        end else if (left_ko_c) begin
            result_c = WIN_RIGHT;
        end else if (right_ko_c) begin
            result_c = WIN_LEFT;
        end else if (round_timer == '0) begin
            result_c = pick_winner(left_player_health, right_player_health);
        end

        phase_last_c = (state_q == COUNTDOWN) ? PHASE_W'(COUNTDOWN_TICKS - 1)
                                              : PHASE_W'(ROUND_END_TICKS - 1);
        phase_done_c = (phase_cnt == phase_last_c);

        match_done_c = (left_wins == 2'(WINS_TO_MATCH))
                    || (right_wins == 2'(WINS_TO_MATCH))
                    || (round_count == ROUND_W'(MAX_ROUNDS));

        start_ok_c        = start && ((state_q == IDLE) || (state_q == MATCH_OVER));
        enter_countdown_c = start_ok_c
                         || ((state_q == ROUND_END) && tick && phase_done_c && !match_done_c);
        clear_c           = (state_q == IDLE) || enter_countdown_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            players_rst_n     <= 1'b0;
            left_cmd          <= ACT_NONE;
            right_cmd         <= ACT_NONE;
            round_timer       <= '0;
            left_wins         <= '0;
            right_wins        <= '0;
            round_winner      <= WIN_NONE;
            match_over        <= 1'b0;
            match_winner      <= WIN_NONE;
            phase_cnt         <= '0;
            round_count       <= '0;
            prev_left_health  <= THREE;
            prev_right_health <= THREE;
            last_left_cmd     <= ACT_NONE;
            last_right_cmd    <= ACT_NONE;
        end else begin
            players_rst_n <= 1'b1;
            left_cmd      <= ACT_NONE;
            right_cmd     <= ACT_NONE;

            // Every new round starts from fresh player blocks and a clean history.
            if (enter_countdown_c) begin
                players_rst_n     <= 1'b0;
                phase_cnt         <= '0;
                round_winner      <= WIN_NONE;
                prev_left_health  <= THREE;
                prev_right_health <= THREE;
                last_left_cmd     <= ACT_NONE;
                last_right_cmd    <= ACT_NONE;
            end

            case (state_q)
                IDLE, MATCH_OVER: begin
                    if (start_ok_c) begin
                        state_q      <= COUNTDOWN;
                        left_wins    <= '0;
                        right_wins   <= '0;
                        round_count  <= '0;
                        match_over   <= 1'b0;
                        match_winner <= WIN_NONE;
                    end
                end

                COUNTDOWN: begin
                    if (tick) begin
                        if (phase_done_c) begin
                            state_q     <= FIGHT;
                            phase_cnt   <= '0;
                            round_timer <= TIMER_W'(ROUND_TICKS);
                        end else begin
                            phase_cnt <= phase_cnt + PHASE_W'(1);
                        end
                    end
                end

                FIGHT: begin
                    if (tick) begin
                        left_cmd       <= left_act_c;
                        right_cmd      <= right_act_c;
                        last_left_cmd  <= left_act_c;
                        last_right_cmd <= right_act_c;
                        if (round_timer != '0) begin
                            round_timer <= round_timer - TIMER_W'(1);
                        end
                    end
                    if (eval) begin
                        prev_left_health  <= left_player_health;
                        prev_right_health <= right_player_health;
                        if (result_c != WIN_NONE) begin
                            state_q      <= ROUND_END;
                            phase_cnt    <= '0;
                            round_winner <= result_c;
                            round_count  <= round_count + ROUND_W'(1);
                            if ((result_c == WIN_LEFT) && (left_wins != 2'(WINS_TO_MATCH))) begin
                                left_wins <= left_wins + 2'd1;
                            end
                            if ((result_c == WIN_RIGHT) && (right_wins != 2'(WINS_TO_MATCH))) begin
                                right_wins <= right_wins + 2'd1;
                            end
                        end
                    end
                end

                ROUND_END: begin
                    if (tick) begin
                        if (phase_done_c) begin
                            phase_cnt <= '0;
                            if (match_done_c) begin
                                state_q      <= MATCH_OVER;
                                match_over   <= 1'b1;
                                match_winner <= pick_winner(left_wins, right_wins);
                            end else begin
                                state_q <= COUNTDOWN;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + PHASE_W'(1);
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_fight_round_controller.sv
// Directed bench for fight_round_controller with a queued expectation scoreboard.
module tb_fight_round_controller;
    import fight_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] left_player_input;
    logic [5:0] right_player_input;
    logic [1:0] left_player_health;
    logic [1:0] right_player_health;
    logic [5:0] left_cmd;
    logic [5:0] right_cmd;
    logic       players_rst_n;
    logic [4:0] round_timer;
    logic [1:0] left_wins;
    logic [1:0] right_wins;
    logic [1:0] round_winner;
    logic       match_over;
    logic [1:0] match_winner;
    logic [2:0] state;

    int          n_checks;
    int          n_fail;
    int          exp_timer;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    fight_round_controller dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .left_player_input   (left_player_input),
        .right_player_input  (right_player_input),
        .left_player_health  (left_player_health),
        .right_player_health (right_player_health),
        .left_cmd            (left_cmd),
        .right_cmd           (right_cmd),
        .players_rst_n       (players_rst_n),
        .round_timer         (round_timer),
        .left_wins           (left_wins),
        .right_wins          (right_wins),
        .round_winner        (round_winner),
        .match_over          (match_over),
        .match_winner        (match_winner),
        .state               (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] model_sanitize(input logic [5:0] a);
        return ($countones(a) == 1) ? a : 6'b000000;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_next(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h with no expectation queued", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        expect_val(tag, e);
        check_next(obs);
    endtask

    task automatic check_reset_values(input string ctx);
        chk({ctx, "_state"},        32'(state),         32'(IDLE));
        chk({ctx, "_players_rst"},  32'(players_rst_n), 32'd0);
        chk({ctx, "_left_cmd"},     32'(left_cmd),      32'd0);
        chk({ctx, "_right_cmd"},    32'(right_cmd),     32'd0);
        chk({ctx, "_round_timer"},  32'(round_timer),   32'd0);
        chk({ctx, "_left_wins"},    32'(left_wins),     32'd0);
        chk({ctx, "_right_wins"},   32'(right_wins),    32'd0);
        chk({ctx, "_round_winner"}, 32'(round_winner),  32'(WIN_NONE));
        chk({ctx, "_match_over"},   32'(match_over),    32'd0);
        chk({ctx, "_match_winner"}, 32'(match_winner),  32'(WIN_NONE));
    endtask

    // Called in the first COUNTDOWN cycle; returns in the first FIGHT cycle.
    task automatic countdown_tail();
        step(1);
        chk("players_rst_released", 32'(players_rst_n), 32'd1);
        step(7);
        chk("countdown_last_cycle", 32'(state), 32'(COUNTDOWN));
        step(1);
        chk("fight_entry_state", 32'(state), 32'(FIGHT));
        chk("fight_entry_timer", 32'(round_timer), 32'd30);
        exp_timer = 30;
    endtask

    task automatic start_match();
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("start_state",        32'(state),         32'(COUNTDOWN));
        chk("start_players_rst",  32'(players_rst_n), 32'd0);
        chk("start_left_wins",    32'(left_wins),     32'd0);
        chk("start_right_wins",   32'(right_wins),    32'd0);
        chk("start_round_winner", 32'(round_winner),  32'(WIN_NONE));
        chk("start_match_over",   32'(match_over),    32'd0);
        chk("start_match_winner", 32'(match_winner),  32'(WIN_NONE));
        countdown_tail();
    endtask

    // Entered on the cycle a tick command is presented; leaves on the next such cycle.
    task automatic fight_step(input logic [5:0] lin, input logic [5:0] rin,
                              input logic [1:0] lh, input logic [1:0] rh);
        left_player_input   = lin;
        right_player_input  = rin;
        left_player_health  = lh;
        right_player_health = rh;
        expect_val("left_cmd_gap", 32'd0);
        expect_val("right_cmd_gap", 32'd0);
        expect_val("left_cmd", 32'(model_sanitize(lin)));
        expect_val("right_cmd", 32'(model_sanitize(rin)));
        if (exp_timer > 0) exp_timer--;
        expect_val("round_timer", 32'(exp_timer));
        expect_val("fight_state", 32'(FIGHT));
        step(1);
        check_next(32'(left_cmd));
        check_next(32'(right_cmd));
        step(3);
        check_next(32'(left_cmd));
        check_next(32'(right_cmd));
        check_next(32'(round_timer));
        check_next(32'(state));
    endtask

    task automatic end_round(input logic [1:0] lh, input logic [1:0] rh,
                             input logic [1:0] exp_rw, input logic [1:0] exp_lwins,
                             input logic [1:0] exp_rwins, input logic is_final,
                             input logic [1:0] exp_mw);
        left_player_health  = lh;
        right_player_health = rh;
        step(2);
        chk("result_state",        32'(state),        32'(ROUND_END));
        chk("result_round_winner", 32'(round_winner), 32'(exp_rw));
        chk("result_left_wins",    32'(left_wins),    32'(exp_lwins));
        chk("result_right_wins",   32'(right_wins),   32'(exp_rwins));
        step(5);
        chk("round_end_hold", 32'(state), 32'(ROUND_END));
        step(1);
        left_player_health  = THREE;
        right_player_health = THREE;
        if (is_final) begin
            chk("final_state",        32'(state),         32'(MATCH_OVER));
            chk("final_match_over",   32'(match_over),    32'd1);
            chk("final_match_winner", 32'(match_winner),  32'(exp_mw));
            chk("final_players_rst",  32'(players_rst_n), 32'd1);
        end else begin
            chk("next_round_state",   32'(state),         32'(COUNTDOWN));
            chk("next_round_rst",     32'(players_rst_n), 32'd0);
            chk("next_round_cleared", 32'(round_winner),  32'(WIN_NONE));
            chk("next_round_no_over", 32'(match_over),    32'd0);
            countdown_tail();
        end
    endtask

    initial begin
        n_checks            = 0;
        n_fail              = 0;
        exp_timer           = 0;
        rst_n               = 1'b0;
        start               = 1'b0;
        left_player_input   = 6'b000000;
        right_player_input  = 6'b000000;
        left_player_health  = THREE;
        right_player_health = THREE;

        step(2);
        check_reset_values("reset");
        rst_n = 1'b1;
        step(1);
        chk("idle_players_rst", 32'(players_rst_n), 32'd1);
        chk("idle_state",       32'(state),         32'(IDLE));

        // Match 1: invalid input, KO by zero health, then wrap-around KO ends the match.
        start_match();
        fight_step(6'b000011, ACT_WAIT, THREE, THREE);
        fight_step(ACT_KICK, ACT_PUNCH, THREE, THREE);
        end_round(THREE, 2'd0, WIN_LEFT, 2'd1, 2'd0, 1'b0, WIN_NONE);
        fight_step(ACT_PUNCH, ACT_WAIT, THREE, THREE);
        fight_step(ACT_PUNCH, ACT_WAIT, THREE, ONE);
        end_round(THREE, THREE, WIN_LEFT, 2'd2, 2'd0, 1'b1, WIN_LEFT);

        // Match 2: start ignored mid-fight, timeout win, timeout draw, reset mid-round.
        start_match();
        start = 1'b1;
        fight_step(ACT_MOVE_RIGHT, ACT_MOVE_LEFT, TWO, ONE);
        start = 1'b0;
        chk("start_ignored_players_rst", 32'(players_rst_n), 32'd1);
        repeat (29) fight_step(ACT_JUMP, ACT_WAIT, TWO, ONE);
        end_round(TWO, ONE, WIN_LEFT, 2'd1, 2'd0, 1'b0, WIN_NONE);
        repeat (30) fight_step(ACT_WAIT, ACT_MOVE_LEFT, TWO, TWO);
        end_round(TWO, TWO, WIN_DRAW, 2'd1, 2'd0, 1'b0, WIN_NONE);
        fight_step(ACT_KICK, ACT_WAIT, THREE, THREE);
        fight_step(ACT_KICK, ACT_PUNCH, THREE, THREE);
        chk("pre_reset_left_cmd", 32'(left_cmd), 32'(ACT_KICK));
        rst_n = 1'b0;
        step(1);
        check_reset_values("mid_fight_reset");
        rst_n = 1'b1;
        step(1);

        // Match 3: five drawn rounds exhaust the round limit.
        start_match();
        for (int r = 0; r < 5; r++) begin
            repeat (30) fight_step(ACT_WAIT, ACT_WAIT, TWO, TWO);
            end_round(TWO, TWO, WIN_DRAW, 2'd0, 2'd0, (r == 4), WIN_DRAW);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
